// File: rtl/mips_tb_pkg.sv
// Shared definitions for the MIPS store-bus self-check monitor.
package mips_tb_pkg;

    // Monitor verdict states; PASS, FAIL and TOUT are terminal.
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PASS = 2'd1,
        FAIL = 2'd2,
        TOUT = 2'd3
    } mon_state_e;

    // The test program ends by storing 7 to address 84; address 80 is its
    // only scratch location.
    localparam logic [31:0] PASS_ADR_DEF  = 32'd84;
    localparam logic [31:0] PASS_DATA_DEF = 32'd7;
    localparam logic [31:0] ALLOW_ADR_DEF = 32'd80;

endpackage

// File: rtl/cycle_watchdog.sv
// Watchdog: flags expiry on the TIMEOUT_CYCLES-th enabled edge after reset.
module cycle_watchdog #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic expired
);

    // Loaded with the number of enabled edges still to go before expiry;
    // reaching zero is the terminal count.
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] remain_q;
    logic [CNT_W-1:0] remain_d;

    // Count down while enabled, holding at the terminal count.
    always_comb begin
        remain_d = remain_q;
        if (enable && (remain_q != '0)) begin
            remain_d = remain_q - CNT_W'(1);
        end
    end

    // Counter register, reloaded by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            remain_q <= LOAD_VAL;
        end else begin
            remain_q <= remain_d;
        end
    end

    assign expired = enable && (remain_q == '0);

endmodule

// File: rtl/mem_write_monitor.sv
// Judges a MIPS program run from its data-memory store bus and holds
// sticky done/pass/fail/timeout flags plus the first offending store.
//
// state | meaning
// RUN   | program running, stores being judged, watchdog counting
// PASS  | PASS_DATA stored to PASS_ADR
// FAIL  | wrong data at PASS_ADR or store to a disallowed address
// TOUT  | watchdog expired without a verdict
module mem_write_monitor
    import mips_tb_pkg::*;
#(
    parameter logic [31:0] PASS_ADR       = PASS_ADR_DEF,
    parameter logic [31:0] PASS_DATA      = PASS_DATA_DEF,
    parameter logic [31:0] ALLOW_ADR      = ALLOW_ADR_DEF,
    parameter int          TIMEOUT_CYCLES = 1000,
    parameter int          CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memwrite,
    input  logic [31:0]      dataadr,
    input  logic [31:0]      writedata,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [CNT_W-1:0] store_count,
    output logic [31:0]      fail_adr,
    output logic [31:0]      fail_data
);

    // A narrow store counter must not truncate the watchdog, so the
    // watchdog is widened to whatever TIMEOUT_CYCLES needs.
    localparam int TO_BITS = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int WD_W    = (TO_BITS > CNT_W) ? TO_BITS : CNT_W;

    mon_state_e       state_q, state_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic             tout_q, tout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      fail_adr_q, fail_adr_d;
    logic [31:0]      fail_data_q, fail_data_d;

    logic wd_expired;
    logic store_good_end;
    logic store_bad;

    cycle_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (WD_W)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .enable  (state_q == RUN),
        .expired (wd_expired)
    );

    assign store_good_end = memwrite && (dataadr == PASS_ADR) && (writedata == PASS_DATA);
    assign store_bad      = memwrite && !store_good_end && (dataadr != ALLOW_ADR);

    // Next-state and flag logic; a terminating store outranks watchdog expiry.
    always_comb begin
        state_d     = state_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        tout_d      = tout_q;
        cnt_d       = cnt_q;
        fail_adr_d  = fail_adr_q;
        fail_data_d = fail_data_q;
        if (state_q == RUN) begin
            if (memwrite && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (store_good_end) begin
                state_d = PASS;
                pass_d  = 1'b1;
                done_d  = 1'b1;
            end else if (store_bad) begin
                state_d     = FAIL;
                fail_d      = 1'b1;
                done_d      = 1'b1;
                fail_adr_d  = dataadr;
                fail_data_d = writedata;
            end else if (wd_expired) begin
                state_d = TOUT;
                tout_d  = 1'b1;
                done_d  = 1'b1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            tout_q      <= 1'b0;
            cnt_q       <= '0;
            fail_adr_q  <= '0;
            fail_data_q <= '0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            tout_q      <= tout_d;
            cnt_q       <= cnt_d;
            fail_adr_q  <= fail_adr_d;
            fail_data_q <= fail_data_d;
        end
    end

    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = tout_q;
    assign store_count = cnt_q;
    assign fail_adr    = fail_adr_q;
    assign fail_data   = fail_data_q;

endmodule

// File: doc/mem_write_monitor.md
Name: mem_write_monitor

Overview:
- Synthesizable self-check block that sits directly downstream of the MIPS `top` data-memory write port.
- Consumes the store bus (`memwrite`, `dataadr`, `writedata`) and judges the program's outcome in hardware, with the same pass/fail rules the simulation bench applies.
- Produces sticky done/pass/fail flags, a store counter, a watchdog timeout and a capture of the first offending store.
- Used both for on-FPGA LED status and for bench-independent regression.

Parameters:
- PASS_ADR, 84: store address that ends the run.
- PASS_DATA, 7: data required at PASS_ADR for a pass.
- ALLOW_ADR, 80: only other address allowed to receive stores during the run.
- TIMEOUT_CYCLES, 1000: cycles in RUN without reaching a verdict before forcing a timeout. Must be ≥1.
- CNT_W, 16: width of the store counter and the watchdog counter.

Ports:
- clk, in, 1: system clock. All state updates on the rising edge.
- reset, in, 1: synchronous, active-high reset.
- memwrite, in, 1: store strobe from `top`. Valid for the whole cycle.
- dataadr, in, 32: store byte address from `top`.
- writedata, in, 32: store data from `top`.
- done, out, 1: verdict reached (pass, fail or timeout). Sticky.
- pass, out, 1: successful end of run. Sticky.
- fail, out, 1: illegal store or wrong data at PASS_ADR. Sticky.
- timeout, out, 1: watchdog expired. Sticky.
- store_count, out, CNT_W: number of stores accepted while in RUN.
- fail_adr, out, 32: address of the offending store.
- fail_data, out, 32: data of the offending store.

Behaviour:
- Reset (reset=1 at a rising edge):
  - state←RUN, done/pass/fail/timeout←0, store_count←0, watchdog←0, fail_adr/fail_data←0.
  - Stores presented while reset=1 are ignored.
- States: RUN, PASS, FAIL, TOUT. PASS, FAIL and TOUT are terminal; only reset leaves them.
- Sampling: a store is sampled at the rising edge ending the cycle in which memwrite=1. Flags update at that same edge, so flag latency is 0 cycles after the sampling edge.
- RUN, memwrite=1, evaluated in this priority order:
  - dataadr==PASS_ADR and writedata==PASS_DATA → PASS; pass←1, done←1.
  - dataadr==PASS_ADR and writedata!=PASS_DATA → FAIL; fail←1, done←1; capture adr/data.
  - dataadr==ALLOW_ADR → stay in RUN. Data is not checked.
  - Any other address → FAIL; fail←1, done←1; capture adr/data.
- store_count:
  - Increments on every store sampled in RUN, including the terminating one.
  - Saturates at all-ones; no wrap.
  - Frozen in terminal states.
- Watchdog:
  - Counts RUN cycles: cleared by reset, +1 at each RUN edge.
  - When it reaches TIMEOUT_CYCLES-1 and the current edge has no terminating store → TOUT; timeout←1, done←1.
  - If a terminating store and expiry coincide, the store wins (PASS or FAIL); timeout stays 0.
- Outputs are registered, with no combinational path from inputs to outputs.
- At most one of pass/fail/timeout is ever 1. done = pass|fail|timeout, implemented as a register.
- In terminal states further stores are ignored: counter, flags and captured values are all unchanged.
- Reset asserted mid-run or in a terminal state restarts cleanly on the next edge.
- Addresses compare on all 32 bits. No alignment masking.

Decomposition:
- Shared package mips_tb_pkg:
  - monitor state enum (RUN, PASS, FAIL, TOUT).
  - default constants PASS_ADR_DEF=84, PASS_DATA_DEF=7, ALLOW_ADR_DEF=80.
- One sub-module, cycle_watchdog:
  - Ports: clk, reset, enable, expired.
  - Parameters: TIMEOUT_CYCLES, CNT_W.
  - Instantiated once with enable = (state==RUN).

Test Plan:
- Reset held 2 cycles, then store (80,5), (80,9), (84,7) in separate cycles → pass=1 and done=1 at the (84,7) edge; store_count=3; fail=0; timeout=0.
- After reset, store (84,8) → fail=1; fail_adr=84; fail_data=8; store_count=1.
- Store (80,1) then (88,0xDEADBEEF) → fail=1; fail_adr=88; fail_data=0xDEADBEEF. A later (84,7) leaves pass=0 and store_count=2.
- TIMEOUT_CYCLES=10, no stores → timeout=1 on the 10th edge after reset deassertion. A store of (84,7) exactly on that edge instead yields pass=1, timeout=0.
- Reach PASS, assert reset 1 cycle → all flags 0 and store_count=0. Then a (84,7) store passes again.
- CNT_W=2, issue 5 stores to 80 → store_count saturates at 3. A subsequent (84,7) still gives pass=1.
